// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: synchronizes the PS/2 clock and data lines,
// deframes 11-bit frames, folds E0/F0 prefixes into flags and hands codes out on valid/ready.
module ps2_rx_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] code_o,
  output logic       ext_o,
  output logic       brk_o,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic clk_prev;
  logic fall, bit_in;
  logic [7:0] sr;
  logic par;
  logic [2:0] bitcnt;
  logic [TW-1:0] tcnt;
  logic ext_pend, brk_pend;
  logic timeout;
  logic shift_en, par_en, clr_bitcnt, inc_bitcnt, frame_done, abort;
  logic good, frame_ok, frame_bad, is_e0, is_f0, emit;

  // Synchronizers idle high so leaving reset never produces a spurious falling edge.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in  = data_sync[SYNC_STAGES-1];
  assign timeout = (state != IDLE) && (tcnt == T_LAST);
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // A timeout takes priority over a falling edge arriving in the same cycle.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    clr_bitcnt = 1'b0;
    inc_bitcnt = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    if (timeout) begin
      next_state = IDLE;
      abort      = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!bit_in) begin
            next_state = DATA;
            clr_bitcnt = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bitcnt == 3'd7) next_state = PARITY;
          else                inc_bitcnt = 1'b1;
        end
        PARITY: begin
          par_en     = 1'b1;
          next_state = STOP;
        end
        STOP: begin
          frame_done = 1'b1;
          next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  assign good      = ((^sr) ^ par) & bit_in;
  assign frame_ok  = frame_done & good;
  assign frame_bad = frame_done & ~good;
  assign is_e0     = (sr == 8'hE0);
  assign is_f0     = (sr == 8'hF0);
  assign emit      = frame_ok & ~is_e0 & ~is_f0;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sr     <= '0;
      par    <= 1'b0;
      bitcnt <= '0;
    end else begin
      if (shift_en)        sr <= {bit_in, sr[7:1]};
      if (par_en)          par <= bit_in;
      if (clr_bitcnt)      bitcnt <= '0;
      else if (inc_bitcnt) bitcnt <= bitcnt + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n)                      tcnt <= '0;
    else if (state == IDLE || fall)    tcnt <= '0;
    else if (tcnt != T_LAST)           tcnt <= tcnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (abort || frame_bad) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_ok) begin
      if (is_e0)      ext_pend <= 1'b1;
      else if (is_f0) brk_pend <= 1'b1;
      else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  // A code held unaccepted is kept; the new one is dropped and flagged as an overrun.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      valid_o     <= 1'b0;
      code_o      <= '0;
      ext_o       <= 1'b0;
      brk_o       <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= abort | frame_bad;
      overrun_o   <= emit & valid_o & ~ready_i;
      if (emit && (!valid_o || ready_i)) begin
        valid_o <= 1'b1;
        code_o  <= sr;
        ext_o   <= ext_pend;
        brk_o   <= brk_pend;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
